// File: rtl/wb_commit_queue.sv
// wb_commit_queue: in-order write-back queue between EX and regfile/HI-LO; in_* push results (bubbles dropped), wb_* expose and commit the head, fwd_* give the newest pending GPR/HI-LO values, count is occupancy
module wb_commit_queue #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [ADDR_W-1:0]       in_wd,
   input  logic                    in_wreg,
   input  logic [DATA_W-1:0]       in_wdata,
   input  logic [DATA_W-1:0]       in_hi,
   input  logic [DATA_W-1:0]       in_lo,
   input  logic                    in_whilo,
   output logic                    wb_valid,
   input  logic                    wb_ready,
   output logic [ADDR_W-1:0]       wb_wd,
   output logic                    wb_wreg,
   output logic [DATA_W-1:0]       wb_wdata,
   output logic [DATA_W-1:0]       wb_hi,
   output logic [DATA_W-1:0]       wb_lo,
   output logic                    wb_whilo,
   input  logic [ADDR_W-1:0]       fwd_raddr1,
   output logic                    fwd_hit1,
   output logic [DATA_W-1:0]       fwd_data1,
   input  logic [ADDR_W-1:0]       fwd_raddr2,
   output logic                    fwd_hit2,
   output logic [DATA_W-1:0]       fwd_data2,
   output logic                    fwd_hilo_hit,
   output logic [DATA_W-1:0]       fwd_hi,
   output logic [DATA_W-1:0]       fwd_lo,
   output logic [$clog2(DEPTH):0]  count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   logic [PW-1:0]     wr_ptr, rd_ptr, idx;
   logic [ADDR_W-1:0] q_wd    [DEPTH];
   logic              q_wreg  [DEPTH];
   logic              q_whilo [DEPTH];
   logic [DATA_W-1:0] q_wdata [DEPTH];
   logic [DATA_W-1:0] q_hi    [DEPTH];
   logic [DATA_W-1:0] q_lo    [DEPTH];
   logic              push, pop;
   assign in_ready = count < CW'(DEPTH);
   assign push     = in_valid & in_ready & (in_wreg | in_whilo);
   assign wb_valid = count != '0;
   assign pop      = wb_valid & wb_ready & rst;
   assign wb_wreg  = pop & q_wreg[rd_ptr];
   assign wb_whilo = pop & q_whilo[rd_ptr];
   assign wb_wd    = wb_valid ? q_wd[rd_ptr]    : '0;
   assign wb_wdata = wb_valid ? q_wdata[rd_ptr] : '0;
   assign wb_hi    = wb_valid ? q_hi[rd_ptr]    : '0;
   assign wb_lo    = wb_valid ? q_lo[rd_ptr]    : '0;
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            q_wd[wr_ptr]    <= in_wd;
            q_wreg[wr_ptr]  <= in_wreg;
            q_wdata[wr_ptr] <= in_wdata;
            q_hi[wr_ptr]    <= in_hi;
            q_lo[wr_ptr]    <= in_lo;
            q_whilo[wr_ptr] <= in_whilo;
            wr_ptr          <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end
   always_comb begin
      fwd_hit1     = 1'b0;
      fwd_data1    = '0;
      fwd_hit2     = 1'b0;
      fwd_data2    = '0;
      fwd_hilo_hit = 1'b0;
      fwd_hi       = '0;
      fwd_lo       = '0;
      idx          = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PW'(i);
         if (CW'(i) < count) begin
            if (q_wreg[idx] && fwd_raddr1 != '0 && q_wd[idx] == fwd_raddr1) begin
               fwd_hit1  = 1'b1;
               fwd_data1 = q_wdata[idx];
            end
            if (q_wreg[idx] && fwd_raddr2 != '0 && q_wd[idx] == fwd_raddr2) begin
               fwd_hit2  = 1'b1;
               fwd_data2 = q_wdata[idx];
            end
            if (q_whilo[idx]) begin
               fwd_hilo_hit = 1'b1;
               fwd_hi       = q_hi[idx];
               fwd_lo       = q_lo[idx];
            end
         end
      end
   end
endmodule

// File: doc/wb_commit_queue.md
Name: wb_commit_queue

Overview:
- Parametrised write-back stage that sits between EX and the register file / HI-LO register.
- Buffers completed results in a DEPTH-entry in-order queue and commits the oldest one when the register-file write port grants access.
- Drops bubble results that write nothing.
- Forwards the newest pending GPR value (two read ports) and the newest pending HI/LO pair to decode.

Parameters:
- DATA_W, 32, GPR/HI/LO data width.
- ADDR_W, 5, GPR address width.
- DEPTH, 4, queue entries; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  EX result present this cycle.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- in_wd  in  ADDR_W  destination GPR.
- in_wreg  in  1  GPR write enable.
- in_wdata  in  DATA_W  GPR write data.
- in_hi  in  DATA_W  HI write data.
- in_lo  in  DATA_W  LO write data.
- in_whilo  in  1  HI/LO write enable.
- wb_valid  out  1  head entry present.
- wb_ready  in  1  regfile/hilo accept head this cycle.
- wb_wd  out  ADDR_W  head GPR address.
- wb_wreg  out  1  head GPR write enable, gated by wb_valid & wb_ready.
- wb_wdata  out  DATA_W  head GPR data.
- wb_hi  out  DATA_W  head HI data.
- wb_lo  out  DATA_W  head LO data.
- wb_whilo  out  1  head HI/LO enable, gated by wb_valid & wb_ready.
- fwd_raddr1  in  ADDR_W  forward lookup address, port 1.
- fwd_hit1  out  1  pending write to fwd_raddr1 exists.
- fwd_data1  out  DATA_W  newest pending data for fwd_raddr1.
- fwd_raddr2, fwd_hit2, fwd_data2  same as port 1.
- fwd_hilo_hit  out  1  pending HI/LO write exists.
- fwd_hi, fwd_lo  out  DATA_W  newest pending HI/LO.
- count  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Reset:
  - rst==0 at a clock edge clears wr_ptr, rd_ptr and count to 0. Storage contents are don't-care.
  - Every output derived from the queue reads 0 while count==0.
  - Reset mid-operation discards all pending entries; nothing is committed in that cycle.
- Push:
  - push = in_valid & in_ready & (in_wreg | in_whilo).
  - in_valid with both enables low is a bubble: dropped and never enqueued.
  - On push, store {in_wd, in_wreg, in_wdata, in_hi, in_lo, in_whilo} at wr_ptr, then wr_ptr++ (wraps mod DEPTH).
- Pop:
  - pop = wb_valid & wb_ready; rd_ptr++ (wraps mod DEPTH).
- Count update:
  - count += push - pop.
  - Simultaneous push and pop leaves count unchanged, including at count==DEPTH-1.
  - in_ready is computed from registered count only. Pushing while full is not allowed, even if a pop occurs in the same cycle.
- Head outputs:
  - Combinational from the head entry. Latency from accepted input to wb_valid is 1 cycle.
  - wb_valid = (count != 0).
  - wb_wd, wb_wdata, wb_hi, wb_lo show the head entry's values whenever wb_valid=1, else 0.
  - wb_wreg / wb_whilo are asserted only in the committing cycle.
- GPR forwarding:
  - Combinational over stored entries only; the in_* entry is visible from the cycle after push.
  - Hit if any valid entry has wreg=1 and wd==fwd_raddrN. Address 0 never hits.
  - With multiple matches, the youngest entry (closest to wr_ptr) wins.
  - No hit: fwd_hitN=0, fwd_dataN=0.
  - An entry popping this cycle still forwards this cycle.
- HI/LO forwarding:
  - Same rule, over entries with whilo=1; youngest wins.
- Ordering:
  - Commits are strictly in push order.
  - An entry with both wreg and whilo commits both in one cycle.

Test Plan:
- Single result:
  - Stimulus: rst released, wb_ready=1; push wd=3, wreg=1, wdata=0x1234.
  - Required: next cycle wb_valid=1, wb_wreg=1, wb_wd=3, wb_wdata=0x1234; following cycle count=0, wb_valid=0.
- Fill and stall:
  - Stimulus: wb_ready=0; push 4 entries, wdata=1..4.
  - Required: count=4, in_ready=0; a 5th in_valid is not accepted.
  - Then wb_ready=1: commits 1,2,3,4 on consecutive cycles.
- Bubble drop and wrap:
  - Stimulus: interleave 3 bubbles (wreg=0, whilo=0) with 6 real pushes while wb_ready toggles 1/0.
  - Required: exactly 6 commits, in order; pointers wrap past DEPTH with no loss or duplicate.
- Forward priority:
  - Stimulus: wb_ready=0; push wd=5 data 0xA, then wd=5 data 0xB; fwd_raddr1=5, fwd_raddr2=0.
  - Required: fwd_hit1=1, fwd_data1=0xB; fwd_hit2=0.
  - After one pop: still 0xB. After second pop: fwd_hit1=0.
- HI/LO path:
  - Stimulus: push whilo=1, hi=0xDEAD, lo=0xBEEF, wreg=0.
  - Required: next cycle fwd_hilo_hit=1, fwd_hi=0xDEAD, fwd_lo=0xBEEF; on commit wb_whilo=1, wb_wreg=0.
- Reset mid-operation:
  - Stimulus: count=3, wb_ready=1; rst=0 for one edge.
  - Required: no commit that cycle; count=0, wb_valid=0, all fwd hits 0 afterwards; the next push commits normally.
